// File: rtl/pp_seq_tx.sv
// Serial pattern transmitter: shifts a latched word out MSB-first on w, each bit
// held DIV clocks, with GAP zero bit-periods between repetitions.
module pp_seq_tx #(
    parameter int WIDTH = 16,
    parameter int DIV   = 1,
    parameter int GAP   = 2
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [WIDTH-1:0]               data_in,
    input  logic [$clog2(WIDTH+1)-1:0]     len_in,
    input  logic [3:0]                     rep_in,
    input  logic                           start,
    output logic                           ready,
    output logic                           busy,
    output logic                           w,
    output logic                           w_valid,
    output logic                           done
);

    localparam int LW   = $clog2(WIDTH + 1);
    localparam int IW   = $clog2(WIDTH);
    localparam int DW   = $clog2(DIV + 1);
    localparam int GCNT = GAP * DIV;
    localparam int GW   = (GCNT > 0) ? $clog2(GCNT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t            state_q, state_n;
    logic [WIDTH-1:0]  data_q, data_n;
    logic [IW-1:0]     top_q, top_n;
    logic [IW-1:0]     idx_q, idx_n;
    logic [DW-1:0]     div_q, div_n;
    logic [GW-1:0]     gap_q, gap_n;
    logic [3:0]        rep_q, rep_n;
    logic              w_n, wv_n, busy_n, done_n;

    logic [LW-1:0]     len_eff;
    logic [IW-1:0]     top_start;

    // Zero and out-of-range lengths both mean a full-width pattern.
    assign len_eff   = (len_in == '0 || len_in > LW'(WIDTH)) ? LW'(WIDTH) : len_in;
    assign top_start = IW'(len_eff - LW'(1));
    assign ready     = (state_q == S_IDLE);

    always_comb begin
        state_n = state_q;
        data_n  = data_q;
        top_n   = top_q;
        idx_n   = idx_q;
        div_n   = div_q;
        gap_n   = gap_q;
        rep_n   = rep_q;
        w_n     = 1'b0;
        wv_n    = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_n  = data_in;
                    top_n   = top_start;
                    rep_n   = rep_in;
                    idx_n   = top_start;
                    div_n   = '0;
                    state_n = S_SHIFT;
                    w_n     = data_in[top_start];
                    wv_n    = 1'b1;
                    busy_n  = 1'b1;
                end
            end

            S_SHIFT: begin
                busy_n = 1'b1;
                wv_n   = 1'b1;
                if (div_q == DW'(DIV - 1)) begin
                    div_n = '0;
                    if (idx_q != '0) begin
                        idx_n = idx_q - 1'b1;
                        w_n   = data_q[idx_q - 1'b1];
                    end else if (rep_q != '0) begin
                        rep_n = rep_q - 1'b1;
                        if (GCNT > 0) begin
                            state_n = S_GAP;
                            gap_n   = '0;
                            wv_n    = 1'b0;
                        end else begin
                            idx_n = top_q;
                            w_n   = data_q[top_q];
                        end
                    end else begin
                        state_n = S_IDLE;
                        busy_n  = 1'b0;
                        wv_n    = 1'b0;
                        done_n  = 1'b1;
                    end
                end else begin
                    div_n = div_q + 1'b1;
                    w_n   = data_q[idx_q];
                end
            end

            S_GAP: begin
                busy_n = 1'b1;
                if (gap_q == GW'(GCNT - 1)) begin
                    state_n = S_SHIFT;
                    idx_n   = top_q;
                    div_n   = '0;
                    w_n     = data_q[top_q];
                    wv_n    = 1'b1;
                end else begin
                    gap_n = gap_q + 1'b1;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            top_q   <= '0;
            idx_q   <= '0;
            div_q   <= '0;
            gap_q   <= '0;
            rep_q   <= '0;
            w       <= 1'b0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            data_q  <= data_n;
            top_q   <= top_n;
            idx_q   <= idx_n;
            div_q   <= div_n;
            gap_q   <= gap_n;
            rep_q   <= rep_n;
            w       <= w_n;
            w_valid <= wv_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_pp_seq_tx.sv
// Scoreboard bench for pp_seq_tx: one instance with DIV=1/GAP=2, one with DIV=3/GAP=1.
module tb_pp_seq_tx;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    logic [15:0] da, db;
    logic [4:0]  la, lb;
    logic [3:0]  ra, rb;
    logic        sa, sb;
    logic        rdya, busya, wa, wva, donea;
    logic        rdyb, busyb, wb, wvb, doneb;

    pp_seq_tx #(.WIDTH(16), .DIV(1), .GAP(2)) dut_a (
        .Clk(Clk), .Rst(Rst), .data_in(da), .len_in(la), .rep_in(ra), .start(sa),
        .ready(rdya), .busy(busya), .w(wa), .w_valid(wva), .done(donea)
    );

    pp_seq_tx #(.WIDTH(16), .DIV(3), .GAP(1)) dut_b (
        .Clk(Clk), .Rst(Rst), .data_in(db), .len_in(lb), .rep_in(rb), .start(sb),
        .ready(rdyb), .busy(busyb), .w(wb), .w_valid(wvb), .done(doneb)
    );

    typedef struct packed {
        logic w;
        logic wv;
        logic busy;
        logic done;
        logic rdy;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (w,w_valid,busy,done,ready)", tag, got[4:0], exp[4:0]);
        end
    endtask

    function automatic exp_t obs(input int sel);
        if (sel != 0) return {wb, wvb, busyb, doneb, rdyb};
        return {wa, wva, busya, donea, rdya};
    endfunction

    task automatic set_in(input int sel, input logic s, input logic [15:0] d,
                          input logic [4:0] l, input logic [3:0] r);
        if (sel != 0) begin sb = s; db = d; lb = l; rb = r; end
        else          begin sa = s; da = d; la = l; ra = r; end
    endtask

    task automatic set_start(input int sel, input logic s);
        if (sel != 0) sb = s;
        else          sa = s;
    endtask

    // Reference model: one entry per clock after the accepting edge, ending with the done cycle.
    task automatic expect_xfer(input logic [15:0] d, input int len, input int rep,
                               input int dv, input int gp);
        int L;
        L = (len == 0 || len > 16) ? 16 : len;
        for (int r = 0; r <= rep; r++) begin
            for (int i = L - 1; i >= 0; i--)
                for (int c = 0; c < dv; c++)
                    q.push_back(exp_t'({d[i], 1'b1, 1'b1, 1'b0, 1'b0}));
            if (r < rep)
                for (int c = 0; c < gp * dv; c++)
                    q.push_back(exp_t'(5'b00100));
        end
        q.push_back(exp_t'(5'b00011));
    endtask

    task automatic xfer(input int sel, input logic [15:0] d, input logic [4:0] len,
                        input logic [3:0] rep, input bit hold, input int poke, input string tag);
        exp_t e;
        int   k;
        @(negedge Clk);
        set_in(sel, 1'b1, d, len, rep);
        expect_xfer(d, int'(len), int'(rep), (sel != 0) ? 3 : 1, (sel != 0) ? 1 : 2);
        @(posedge Clk);
        #1;
        set_in(sel, hold, ~d, 5'd3, 4'd5);
        k = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("%s.c%0d", tag, k + 1), obs(sel), e);
            if (k == poke)   set_start(sel, 1'b1);
            else if (!hold)  set_start(sel, 1'b0);
            if (q.size() > 0) begin
                @(posedge Clk);
                #1;
            end
            k++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        Rst = 1'b1;
        set_in(0, 1'b0, 16'h0, 5'd0, 4'd0);
        set_in(1, 1'b0, 16'h0, 5'd0, 4'd0);
        #12;
        chk("reset_a", obs(0), 5'b00001);
        chk("reset_b", obs(1), 5'b00001);
        @(negedge Clk);
        Rst = 1'b0;

        xfer(0, 16'h0009, 5'd4, 4'd0, 1'b0, -1, "basic");
        xfer(0, 16'h0007, 5'd3, 4'd2, 1'b0, -1, "rep_gap");
        xfer(1, 16'h0002, 5'd2, 4'd0, 1'b0, -1, "div3");
        xfer(0, 16'hA5C3, 5'd0, 4'd0, 1'b0, 5, "len0_ign");
        xfer(0, 16'h00F0, 5'd20, 4'd0, 1'b0, -1, "clamp");
        xfer(1, 16'h0001, 5'd1, 4'd1, 1'b0, -1, "len1_div3");
        xfer(0, 16'h0005, 5'd3, 4'd1, 1'b1, -1, "b2b_1");
        xfer(0, 16'h0006, 5'd3, 4'd0, 1'b0, -1, "b2b_2");

        // Asynchronous reset in the middle of a transfer.
        @(negedge Clk);
        set_in(0, 1'b1, 16'hA5C3, 5'd0, 4'd0);
        expect_xfer(16'hA5C3, 0, 0, 1, 2);
        @(posedge Clk);
        #1;
        set_start(0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            e = q.pop_front();
            chk($sformatf("arst_pre.c%0d", k + 1), obs(0), e);
            if (k < 2) begin
                @(posedge Clk);
                #1;
            end
        end
        q.delete();
        #2;
        Rst = 1'b1;
        #1;
        chk("arst_now", obs(0), 5'b00001);
        @(posedge Clk);
        #1;
        chk("arst_held", obs(0), 5'b00001);
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        chk("arst_nodone", obs(0), 5'b00001);
        xfer(0, 16'h0009, 5'd4, 4'd0, 1'b0, -1, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pp_seq_tx.md
Name: pp_seq_tx

Overview:
Serial pattern transmitter. Drives the single-bit stream `w` that the team's serial sequence-detector FSMs consume, where the detectors look for patterns such as 1001 and 111. It loads a parallel word, a bit length and a repeat count. It then shifts the word out MSB-first, holding each bit for DIV clocks, and inserts zero-filled gap bits between repetitions. It serves as the stimulus/source end of the detector interface, in benches and in on-chip self-test.

Parameters:
WIDTH, 16, maximum pattern length in bits (2..32)
DIV, 1, clocks per transmitted bit (>=1)
GAP, 2, idle '0' bit periods inserted between repetitions (>=0)

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous, active-high reset
data_in  input  WIDTH  pattern; bits [len-1:0] are used, bit len-1 is sent first
len_in  input  clog2(WIDTH+1)  number of bits to send; 0 means WIDTH
rep_in  input  4  extra repetitions; total sends = rep_in+1
start  input  1  request; accepted only when ready=1
ready  output  1  1 in IDLE, so a start would be accepted
busy  output  1  1 from the cycle after acceptance until return to IDLE
w  output  1  serial data to the detector
w_valid  output  1  1 while `w` carries a pattern bit; 0 during gap and idle
done  output  1  one-cycle pulse when the final bit period ends

Behaviour:
- Interface decision: one clock, `Clk`. Reset `Rst` is asynchronous and active-high. All state and outputs clear immediately on `Rst`=1, independent of `Clk`.
- Reset values: w=0, w_valid=0, busy=0, done=0, ready=1, FSM=IDLE, all counters 0.
- All outputs are registered, except `ready`, which equals (state==IDLE).
- States: IDLE, SHIFT, GAP.
- IDLE:
  - w=0, w_valid=0.
  - If start=1 at a clock edge, latch data_in, the effective length L (len_in==0 gives WIDTH) and rep_in.
  - Go to SHIFT with bit index = L-1 and div count = 0.
- Latency: the first bit appears on `w`, with w_valid=1 and busy=1, in the cycle after the start edge.
- SHIFT:
  - w = latched_data[index]; w_valid=1.
  - Each bit is held exactly DIV cycles. Then index decrements.
  - After bit 0 completes its DIV cycles:
    - if remaining reps > 0: decrement reps; go to GAP if GAP>0, otherwise go straight to SHIFT with index = L-1 (back-to-back repetition);
    - if remaining reps = 0: go to IDLE and pulse done=1 in the first IDLE cycle.
- GAP:
  - w=0, w_valid=0, busy=1, for GAP*DIV cycles.
  - Then go to SHIFT with index = L-1, using the same latched word.
- Total busy duration = (rep_in+1)*L*DIV + rep_in*GAP*DIV cycles.
- Boundary conditions:
  - start while busy: ignored, with no effect on the latched values.
  - start in the same cycle done pulses: accepted, because ready=1. The new first bit appears the next cycle, with no idle bit between the two transfers.
  - data_in, len_in and rep_in may change after acceptance without effect.
  - len_in > WIDTH: clamp to WIDTH.
  - L=1: a single bit per repetition.
  - Rst asserted mid-SHIFT or mid-GAP: outputs drop to reset values immediately and the transfer is abandoned, with no done pulse. Operation resumes from IDLE after Rst deasserts.
- Counters:
  - div count width is clog2(DIV+1);
  - gap count must reach GAP*DIV without overflow;
  - no wrap-around is allowed in any counter.

Test Plan:
- Basic send: DIV=1, GAP=2, data_in=16'h0009, len_in=4, rep_in=0, start pulsed at cycle 0 -> cycles 1-4 give w=1,0,0,1 with w_valid=1. done=1 in cycle 5, ready=1 in cycle 5. With `w` driven into the 1001/111 detector, the detector's z=1 after the 4th bit.
- Repeats with gap: data_in=16'h0007, len_in=3, rep_in=2, GAP=2 -> w = 111 00 111 00 111. w_valid=0 on the four gap bits. busy lasts 13 cycles, then one done pulse.
- Bit divider: DIV=3, data_in=16'h0002, len_in=2, rep_in=0 -> w = 1 for 3 cycles, then 0 for 3 cycles. done in cycle 7.
- Length handling: len_in=0 with data_in=16'hA5C3 -> all 16 bits MSB-first, 1010010111000011. A second start asserted during the transfer is ignored (busy stays 1, sequence unchanged).
- Back-to-back: start held high continuously -> the next transfer begins the cycle after done, with no extra idle bit.
- Async reset: Rst asserted mid-cycle during SHIFT bit 2 -> w, w_valid and busy go to 0 before the next Clk edge, no done pulse, ready=1. A subsequent start works normally.
